// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB/AND/OR/XOR/LSL/LSR/MUL with valid/ready handshake,
// registered result + NZCV flags and a sticky flag register. MUL is built only with ALU_MC_MUL_EN.
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         set_flags,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic [3:0]   flags_q
);

    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   result_reg, result_next;
    logic [3:0]     flags_reg, flags_next;
    logic [3:0]     flags_q_reg, flags_q_next;
    logic           sf_reg, sf_next;
    logic           accept;

    // Single-cycle datapath
    logic [N:0]     add_ext;
    logic [N:0]     sub_ext;
    logic [N:0]     shl_ext;
    logic [N:0]     shr_ext;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   alu_res;
    logic           alu_c;
    logic           alu_v;
    logic [3:0]     alu_flags;

    assign shamt   = op_b[SW-1:0];
    assign add_ext = {1'b0, op_a} + {1'b0, op_b};
    assign sub_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
    // The extra bit on each shift catches the last bit shifted out; zero for shamt 0.
    assign shl_ext = {1'b0, op_a} << shamt;
    assign shr_ext = {op_a, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_ext[N-1:0];
                alu_c   = add_ext[N];
                alu_v   = (op_a[N-1] == op_b[N-1]) && (add_ext[N-1] != op_a[N-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[N-1:0];
                alu_c   = sub_ext[N];
                alu_v   = (op_a[N-1] != op_b[N-1]) && (sub_ext[N-1] != op_a[N-1]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_LSL: begin
                alu_res = shl_ext[N-1:0];
                alu_c   = shl_ext[N];
            end
            OP_LSR: begin
                alu_res = shr_ext[N:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res[N-1], (alu_res == '0), alu_c, alu_v};

`ifdef ALU_MC_MUL_EN
    localparam int CW = $clog2(N) + 1;

    logic [2*N-1:0] mcand_reg, mcand_next;
    logic [N-1:0]   mplier_reg, mplier_next;
    logic [2*N-1:0] acc_reg, acc_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*N-1:0] acc_step;

    assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : {(2*N){1'b0}});
`endif

    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == ST_HOLD);
    assign result    = result_reg;
    assign flags     = flags_reg;
    assign flags_q   = flags_q_reg;

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        flags_next   = flags_reg;
        flags_q_next = flags_q_reg;
        sf_next      = sf_reg;
`ifdef ALU_MC_MUL_EN
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
`endif

        // Consumption of the held result; an accept below may override the next state.
        if ((state_reg == ST_HOLD) && out_ready) begin
            if (sf_reg) begin
                flags_q_next = flags_reg;
            end
            state_next = ST_IDLE;
        end

`ifdef ALU_MC_MUL_EN
        if (state_reg == ST_MUL) begin
            acc_next    = acc_step;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
                state_next  = ST_HOLD;
                result_next = acc_step[N-1:0];
                flags_next  = {acc_step[N-1], (acc_step[N-1:0] == '0),
                               (acc_step[2*N-1:N] != '0), 1'b0};
            end
        end
`endif

        if (accept) begin
            sf_next = set_flags;
`ifdef ALU_MC_MUL_EN
            if (op == OP_MUL) begin
                mcand_next  = {{N{1'b0}}, op_a};
                mplier_next = op_b;
                acc_next    = '0;
                cnt_next    = CW'(N);
                state_next  = ST_MUL;
            end else begin
                result_next = alu_res;
                flags_next  = alu_flags;
                state_next  = ST_HOLD;
            end
`else
            result_next = alu_res;
            flags_next  = alu_flags;
            state_next  = ST_HOLD;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            result_reg  <= '0;
            flags_reg   <= '0;
            flags_q_reg <= '0;
            sf_reg      <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            flags_reg   <= flags_next;
            flags_q_reg <= flags_q_next;
            sf_reg      <= sf_next;
`ifdef ALU_MC_MUL_EN
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
`endif
        end
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the pipeline execute stage, replacing the purely combinational 4-op ALU. Accepts one operation per valid/ready handshake, produces a registered result and NZCV flags, and supports XOR, logical shifts and an iterative unsigned multiply in addition to add/sub/and/or. Holds a sticky condition-flag register that is updated only by operations that request it.

## Interface
Parameters:
- N, 32, operand/result width (N ≥ 8, power of two)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept operation this cycle
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL
- set_flags  in  1  update sticky flag register when this result is consumed
- op_a  in  N  operand A
- op_b  in  N  operand B (shift amount = op_b[$clog2(N)-1:0] for LSL/LSR)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  N  operation result
- flags  out  4  per-result flags: [0]=V, [1]=C, [2]=Z, [3]=N
- flags_q  out  4  sticky flag register, same bit order

## Operation
- States: IDLE (no result held), MUL (multiply in progress), HOLD (result held, out_valid=1).
- Accept = in_valid && in_ready. in_ready = 1 in IDLE; = out_ready in HOLD; = 0 in MUL.
- On accept of non-MUL op: result/flags registered, next state HOLD.
- On accept of MUL: latch operands, counter = N, next state MUL; one shift-add step per cycle; when counter reaches 0, next state HOLD.
- In HOLD: out_valid && out_ready with no accept -> IDLE; with accept -> behaves as accept from IDLE (back-to-back).
- Arithmetic: ADD = op_a + op_b; SUB = op_a + ~op_b + 1. C = carry-out of N-bit adder (SUB: C=1 means no borrow). V = signed overflow: operands' sign relation (equal for ADD, differing for SUB) and result sign differs from op_a.
- AND/OR/XOR: C=0, V=0.
- LSL/LSR: zero fill; C = last bit shifted out; shift amount 0 -> result = op_a, C=0. V=0.
- MUL: unsigned, result = low N bits of 2N-bit product; C = 1 iff high N bits nonzero; V=0.
- Z = (result == 0) over all N bits; N = result[N-1]; for every op.
- flags_q <= flags on the cycle the result is consumed (out_valid && out_ready) iff set_flags was 1 at accept; otherwise unchanged.
- op/operands/set_flags sampled only at accept; changes at other times ignored.

## Timing
- Reset (rst_n low, any state, including mid-MUL): state IDLE, out_valid=0, result=0, flags=0, flags_q=0, counter=0; takes effect immediately, aborted MUL lost.
- Non-MUL latency: accept at edge t -> out_valid=1 after edge t; throughput 1 op/cycle with out_ready held high.
- MUL latency: accept at edge t -> out_valid=1 after edge t+N; in_ready=0 during the N MUL cycles.
- result/flags stable while out_valid=1 and out_ready=0.
- flags_q change visible the cycle after the consuming edge.

## Configuration
- ALU_MC_MUL_EN defined: MUL implemented as above.
- Not defined: no multiplier/counter logic; op 111 completes in one cycle like other ops with result=0, flags=4'b0100 (Z only); MUL state unreachable.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, set_flags=1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1; flags_q=4'b1001 after consume.
- SUB 5 - 5, then SUB 3 - 5 back-to-back, out_ready=1 -> 0 with Z=1 C=1; then 0xFFFFFFFE with N=1 C=0; one result per cycle.
- LSL 0x80000001 by 1 -> 0x00000002, C=1; LSR 0x1 by 0 -> 0x1, C=0; XOR 0xFFFF0000^0xFFFF0000 -> 0, Z=1, set_flags=0 -> flags_q unchanged.
- MUL 0x10000 * 0x10000 (ALU_MC_MUL_EN) -> out_valid exactly 32 cycles after accept, result 0, Z=1, C=1; in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> result stable, in_ready=0, no new op accepted; rst_n pulsed during MUL -> out_valid=0, flags_q=0 immediately.
- Without ALU_MC_MUL_EN: MUL 3*4 -> result 0, flags 4'b0100, latency 1.
